// File: rtl/key_adjust_ctrl.sv
// key_adjust_ctrl: ADD/NEXT button front end (sync, debounce, edge detect, field cursor).
// Define AUTO_REPEAT_EN to enable hold-to-repeat on ADD; otherwise one pulse per press.
module key_adjust_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter int FIELD_NUM    = 7
) (
  input  logic       CLOCK_50,
  input  logic       clr,
  input  logic       key_add_n,
  input  logic       key_next_n,
  input  logic       adjust,
  output logic       add_pulse,
  output logic [3:0] sel,
  output logic [1:0] held
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [2:0] s1, s2;
  logic [1:0] deb, deb_q, press;
  logic       adj, step;
  always_ff @(posedge CLOCK_50 or negedge clr)
    if (!clr) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {adjust, key_next_n, key_add_n};
      s2 <= s1;
    end
  // synced level must differ for DEBOUNCE_CYC+1 consecutive samples before deb follows
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          d;
    always_ff @(posedge CLOCK_50 or negedge clr)
      if (!clr) begin
        cnt <= '0;
        d   <= 1'b0;
      end else if (s2[i] != d) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYC)) begin
        cnt <= '0;
        d   <= !s2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign deb[i] = d;
  end
  assign adj   = s2[2];
  assign press = deb & ~deb_q;
  assign held  = deb;
  // cursor moves one cycle after the press so a coincident add_pulse sees the old sel
  always_ff @(posedge CLOCK_50 or negedge clr)
    if (!clr) begin
      deb_q <= 2'b00;
      step  <= 1'b0;
      sel   <= 4'd0;
    end else begin
      deb_q <= deb;
      step  <= adj & press[1];
      if (step) sel <= (sel == 4'(FIELD_NUM - 1)) ? 4'd0 : sel + 4'd1;
    end
`ifdef AUTO_REPEAT_EN
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2;
  localparam int CW = $clog2((HOLD_CYC > REPEAT_CYC ? HOLD_CYC : REPEAT_CYC) + 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLOCK_50 or negedge clr)
    if (!clr) begin
      state     <= IDLE;
      cnt       <= '0;
      add_pulse <= 1'b0;
    end else begin
      add_pulse <= 1'b0;
      if (!adj) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (press[0]) begin
          add_pulse <= 1'b1;
          cnt       <= '0;
          state     <= HOLD;
        end
      end else if (!deb[0]) begin
        state <= IDLE;
      end else if (cnt == CW'(state == HOLD ? HOLD_CYC - 1 : REPEAT_CYC - 1)) begin
        add_pulse <= 1'b1;
        cnt       <= '0;
        state     <= REPEAT;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
`else
  always_ff @(posedge CLOCK_50 or negedge clr)
    if (!clr) add_pulse <= 1'b0;
    else add_pulse <= adj & press[0];
`endif
endmodule

// File: tb/tb_key_adjust_ctrl.sv
// tb_key_adjust_ctrl: directed and random stimulus against a window/arithmetic reference model.
module tb_key_adjust_ctrl;
  localparam int D = 4, H = 20, R = 5, F = 7;
  logic       clk = 1'b0, clr = 1'b0, key_add_n = 1'b1, key_next_n = 1'b1, adjust = 1'b1;
  logic       add_pulse;
  logic [3:0] sel;
  logic [1:0] held;
  int n_cmp = 0, n_bad = 0, cyc = 0, pcnt = 0, last_pc = 0;
  always #5 clk = ~clk;

  key_adjust_ctrl #(.DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .FIELD_NUM(F)) dut (
    .CLOCK_50(clk), .clr(clr), .key_add_n(key_add_n), .key_next_n(key_next_n),
    .adjust(adjust), .add_pulse(add_pulse), .sel(sel), .held(held));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference: debounced level flips once the last D+1 synced samples all disagree with it;
  // pulses follow from press age: 0, H, then every R while held and adjust stays on
  logic [2:0]   k1, k2;
  logic [D-1:0] wa, wn;
  logic [D:0]   win_a, win_n;
  logic         da, dn, dap, dnp, act, act_n, m_pulse, pulse_n, m_step, step_n;
  int           age, age_n, m_sel, sel_n;
  always_comb begin
    win_a   = {wa, k2[0]};
    win_n   = {wn, k2[1]};
    act_n   = act;
    age_n   = age;
    pulse_n = 1'b0;
`ifdef AUTO_REPEAT_EN
    if (!k2[2]) act_n = 1'b0;
    else if (!act) begin
      if (da && !dap) begin
        pulse_n = 1'b1;
        act_n   = 1'b1;
        age_n   = 0;
      end
    end else if (!da) act_n = 1'b0;
    else begin
      age_n   = age + 1;
      pulse_n = (age_n == H) || (age_n > H && (age_n - H) % R == 0);
    end
`else
    pulse_n = k2[2] && da && !dap;
`endif
    step_n = k2[2] && dn && !dnp;
    sel_n  = m_step ? (m_sel + 1) % F : m_sel;
  end
  always @(posedge clk or negedge clr)
    if (!clr) begin
      k1 <= 3'b100; k2 <= 3'b100; wa <= '0; wn <= '0;
      da <= 0; dn <= 0; dap <= 0; dnp <= 0; act <= 0; age <= 0;
      m_pulse <= 0; m_step <= 0; m_sel <= 0;
    end else begin
      k1 <= {adjust, ~key_next_n, ~key_add_n};
      k2 <= k1;
      wa <= win_a[D-1:0];
      wn <= win_n[D-1:0];
      da <= (win_a == {(D+1){~da}}) ? ~da : da;
      dn <= (win_n == {(D+1){~dn}}) ? ~dn : dn;
      dap <= da; dnp <= dn;
      act <= act_n; age <= age_n;
      m_pulse <= pulse_n; m_step <= step_n; m_sel <= sel_n;
    end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    check("pulse", int'(add_pulse), int'(m_pulse));
    check("sel", int'(sel), m_sel);
    check("held", int'(held), int'({dn, da}));
    if (add_pulse) begin
      pcnt++;
      last_pc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    clr = 1'b0; key_add_n = 1'b1; key_next_n = 1'b1; adjust = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(2);
  endtask
  task automatic next_press();
    key_next_n = 1'b0; tick(10);
    key_next_n = 1'b1; tick(10);
  endtask

  initial begin
    int c0, p0, k;
    key_add_n = 1'b0; key_next_n = 1'b0;
    tick(3);
    check("rst_pulse", int'(add_pulse), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_held", int'(held), 0);
    c0 = cyc; p0 = pcnt;
    clr = 1'b1;
    k = 0;
    while (pcnt == p0 && k < 20) begin tick(1); k++; end
    check("rst_seen", pcnt - p0, 1);
    check("rst_lat", last_pc - c0 - 1, 7);
    key_add_n = 1'b1; key_next_n = 1'b1;
    tick(15);

    do_reset();
    key_add_n = 1'b0; tick(3);
    key_add_n = 1'b1; tick(2);
    c0 = cyc; p0 = pcnt;
    key_add_n = 1'b0; tick(30);
    check("bounce_n", pcnt - p0, 1);
    check("bounce_lat", last_pc - c0 - 1, 7);
    key_add_n = 1'b1; tick(15);
    p0 = pcnt;
    key_add_n = 1'b0; tick(3);
    key_add_n = 1'b1; tick(15);
    check("glitch", pcnt - p0, 0);

    p0 = pcnt;
    key_add_n = 1'b0; tick(60);
    key_add_n = 1'b1; tick(15);
`ifdef AUTO_REPEAT_EN
    check("repeat_n", pcnt - p0, 9);
`else
    check("repeat_n", pcnt - p0, 1);
`endif

    do_reset();
    p0 = pcnt;
    for (int i = 0; i < 8; i++) begin
      next_press();
      check("wrap_sel", int'(sel), (i + 1) % F);
    end
    check("wrap_pulse", pcnt - p0, 0);

    adjust = 1'b0; tick(3);
    p0 = pcnt;
    key_add_n = 1'b0; key_next_n = 1'b0; tick(15);
    check("gate_pulse", pcnt - p0, 0);
    check("gate_sel", int'(sel), 1);
    check("gate_held", int'(held), 3);
    key_add_n = 1'b1; key_next_n = 1'b1; tick(15);
    adjust = 1'b1; tick(3);
    key_add_n = 1'b0; tick(30);
    adjust = 1'b0; tick(3);
    p0 = pcnt;
    tick(20);
    check("gate_rep", pcnt - p0, 0);
    key_add_n = 1'b1; tick(12);
    adjust = 1'b1; tick(3);

    do_reset();
    next_press();
    next_press();
    key_add_n = 1'b0; key_next_n = 1'b0;
    k = 0;
    while (!add_pulse && k < 20) begin tick(1); k++; end
    check("sim_pulse", int'(add_pulse), 1);
    check("sim_sel", int'(sel), 2);
    tick(1);
    check("sim_sel_next", int'(sel), 3);
    key_add_n = 1'b1; key_next_n = 1'b1; tick(15);

    for (int i = 0; i < 300; i++) begin
      key_add_n  = 1'($urandom_range(0, 1));
      key_next_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      adjust     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0) begin
        clr = 1'b0; tick(1); clr = 1'b1;
      end
      tick(($urandom_range(0, 4) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
